// File: rtl/game_flow_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : game_flow_ctrl_if                                                |
// | Brief   : Button, timer and status signals of the game flow controller.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface game_flow_ctrl_if;
  logic       btn_start;
  logic       btn_pause;
  logic       time_up;
  logic       fail;
  logic       Start;
  logic       pause;
  logic       game_over;
  logic       playing;
  logic       led_pause;
  logic [3:0] rounds;

  modport master (
    output btn_start, btn_pause, time_up, fail,
    input  Start, pause, game_over, playing, led_pause, rounds
  );

  modport slave (
    input  btn_start, btn_pause, time_up, fail,
    output Start, pause, game_over, playing, led_pause, rounds
  );
endinterface
`default_nettype wire

// File: rtl/game_flow_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : game_flow_ctrl                                                   |
// | Brief   : Debounced start/pause buttons driving an IDLE/RUN/PAUSED/OVER    |
// |           game flow FSM; PAUSE_FEATURE_EN builds the pause path.           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module game_flow_ctrl #(
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic            CLK,
  input  logic            RESET,
  game_flow_ctrl_if.slave gf
);

`ifdef PAUSE_FEATURE_EN
  localparam int c_NBTN     = 2;
  localparam bit c_PAUSE_EN = 1'b1;
`else
  localparam int c_NBTN     = 1;
  localparam bit c_PAUSE_EN = 1'b0;
`endif
  localparam logic [19:0] c_DB_LAST = 20'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  logic [c_NBTN-1:0] w_raw;
  logic [c_NBTN-1:0] w_press;
  logic              w_start_ev;
  logic              w_pause_ev;
  logic [1:0]        prime_q;

  assign w_raw[0] = gf.btn_start;
`ifdef PAUSE_FEATURE_EN
  assign w_raw[1] = gf.btn_pause;
`endif

  // Synchronizer output is only trusted once it has been refilled after reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      prime_q <= 2'd0;
    end else if (prime_q != 2'd2) begin
      prime_q <= prime_q + 2'd1;
    end
  end

  for (genvar gi = 0; gi < c_NBTN; gi++) begin : g_btn
    logic        s1_q, s2_q, db_q, dbd_q, armed_q, press_q;
    logic [19:0] cnt_q;

    // A button must be seen released after reset before its presses count.
    always_ff @(posedge CLK) begin
      if (RESET) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        db_q    <= 1'b0;
        dbd_q   <= 1'b0;
        armed_q <= 1'b0;
        press_q <= 1'b0;
        cnt_q   <= 20'd0;
      end else begin
        s1_q    <= w_raw[gi];
        s2_q    <= s1_q;
        dbd_q   <= db_q;
        press_q <= armed_q & db_q & ~dbd_q;
        if (prime_q == 2'd2 && !s2_q) begin
          armed_q <= 1'b1;
        end
        if (s2_q == db_q) begin
          cnt_q <= 20'd0;
        end else if (cnt_q == c_DB_LAST) begin
          cnt_q <= 20'd0;
          db_q  <= ~db_q;
        end else begin
          cnt_q <= cnt_q + 20'd1;
        end
      end
    end

    assign w_press[gi] = press_q;
  end

  assign w_start_ev = w_press[0];
`ifdef PAUSE_FEATURE_EN
  assign w_pause_ev = w_press[1];
`else
  assign w_pause_ev = 1'b0;
`endif

  state_t     state_q;
  logic       start_q, pause_q, over_q, playing_q, led_q;
  logic [3:0] rounds_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      pause_q   <= 1'b0;
      over_q    <= 1'b0;
      playing_q <= 1'b0;
      led_q     <= 1'b0;
      rounds_q  <= 4'd0;
    end else begin
      start_q <= 1'b0;
      pause_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_start_ev) begin
            state_q   <= S_RUN;
            start_q   <= 1'b1;
            playing_q <= 1'b1;
          end
        end
        S_RUN: begin
          // Timer expiry or a loss always beats a coincident pause request.
          if (gf.time_up || gf.fail) begin
            state_q   <= S_OVER;
            over_q    <= 1'b1;
            playing_q <= 1'b0;
            if (rounds_q != 4'd15) begin
              rounds_q <= rounds_q + 4'd1;
            end
          end else if (w_pause_ev) begin
            state_q   <= S_PAUSED;
            pause_q   <= 1'b1;
            playing_q <= 1'b0;
            led_q     <= 1'b1;
          end
        end
        S_PAUSED: begin
          if (w_start_ev || w_pause_ev) begin
            state_q   <= S_RUN;
            start_q   <= 1'b1;
            playing_q <= 1'b1;
            led_q     <= 1'b0;
          end
        end
        S_OVER: begin
          if (w_start_ev) begin
            state_q <= S_IDLE;
            start_q <= 1'b1;
            over_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          over_q    <= 1'b0;
          playing_q <= 1'b0;
          led_q     <= 1'b0;
        end
      endcase
    end
  end

  assign gf.Start     = start_q;
  assign gf.pause     = pause_q & c_PAUSE_EN;
  assign gf.game_over = over_q;
  assign gf.playing   = playing_q;
  assign gf.led_pause = led_q & c_PAUSE_EN;
  assign gf.rounds    = rounds_q;

endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// Testbench for game_flow_ctrl: behavioural model compared every cycle plus
// literal expectations for latency, pulse counts and round saturation.
module tb_game_flow_ctrl;
  localparam int DB = 4;
`ifdef PAUSE_FEATURE_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_OVER = 3;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;
  bit   chk_en      = 1'b0;

  game_flow_ctrl_if gf ();
  game_flow_ctrl #(.DB_CYCLES(DB)) dut (.CLK(CLK), .RESET(RESET), .gf(gf));

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  bit h1 [2], h2 [2], v1 [2], v2 [2], mdb [2], rose [2], arm [2], mpress [2];
  int streak [2];
  int ms = M_IDLE;
  bit mStart, mPause, mOver, mPlay, mLed;
  int mRounds;

  task automatic model_step();
    bit raw [2];
    bit np  [2];
    bit ev_s, ev_p;
    raw[0] = gf.btn_start;
    raw[1] = gf.btn_pause;
    if (RESET) begin
      for (int b = 0; b < 2; b++) begin
        h1[b] = 0; h2[b] = 0; v1[b] = 0; v2[b] = 0; mdb[b] = 0;
        rose[b] = 0; arm[b] = 0; mpress[b] = 0; streak[b] = 0;
      end
      ms = M_IDLE; mStart = 0; mPause = 0; mOver = 0; mPlay = 0; mLed = 0; mRounds = 0;
      return;
    end
    ev_s = mpress[0];
    ev_p = mpress[1] & PEN;
    for (int b = 0; b < 2; b++) begin
      // press event: one cycle after the debounced level rose, if armed
      np[b]   = rose[b] & arm[b];
      rose[b] = 0;
      if (v2[b] && !h2[b]) arm[b] = 1;
      // level flips after DB consecutive synced samples that disagree with it
      if (h2[b] != mdb[b]) begin
        streak[b]++;
        if (streak[b] == DB) begin
          mdb[b]    = ~mdb[b];
          streak[b] = 0;
          rose[b]   = mdb[b];
        end
      end else begin
        streak[b] = 0;
      end
      h2[b] = h1[b]; v2[b] = v1[b];
      h1[b] = raw[b]; v1[b] = 1;
      mpress[b] = np[b];
    end
    mStart = 0;
    mPause = 0;
    case (ms)
      M_IDLE:   if (ev_s) begin ms = M_RUN; mStart = 1; end
      M_RUN: begin
        if (gf.time_up || gf.fail) begin
          ms = M_OVER;
          if (mRounds < 15) mRounds++;
        end else if (ev_p) begin
          ms = M_PAUSED; mPause = 1;
        end
      end
      M_PAUSED: if (ev_s || ev_p) begin ms = M_RUN; mStart = 1; end
      default:  if (ev_s) begin ms = M_IDLE; mStart = 1; end
    endcase
    mPlay = (ms == M_RUN);
    mLed  = (ms == M_PAUSED);
    mOver = (ms == M_OVER);
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge CLK);
    if (chk_en) begin
      vectors++;
      if (gf.Start !== mStart || gf.pause !== mPause || gf.game_over !== mOver ||
          gf.playing !== mPlay || gf.led_pause !== mLed || gf.rounds !== 4'(mRounds)) begin
        miscompares++;
        $display("FAIL model t=%0t actual S/p/go/pl/lp/r=%b%b%b%b%b/%0d required %b%b%b%b%b/%0d",
                 $time, gf.Start, gf.pause, gf.game_over, gf.playing, gf.led_pause, gf.rounds,
                 mStart, mPause, mOver, mPlay, mLed, mRounds);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    if (b == 0) gf.btn_start = v;
    else        gf.btn_pause = v;
  endtask

  // Hold a button for 'hold' cycles then release for 'rel'; count output pulses.
  task automatic press(input int b, input int hold, input int rel,
                       output int ns, output int np, output int first_s);
    ns = 0; np = 0; first_s = 0;
    for (int k = 1; k <= hold + rel; k++) begin
      set_btn(b, (k <= hold));
      @(negedge CLK);
      if (gf.Start) begin
        ns++;
        if (first_s == 0) first_s = k;
      end
      if (gf.pause) np++;
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic at_neg_levels(input string tag, input logic pl, input logic go, input logic lp,
                               input logic [3:0] r);
    @(negedge CLK);
    chk({tag, "_playing"}, gf.playing, pl);
    chk({tag, "_game_over"}, gf.game_over, go);
    chk({tag, "_led_pause"}, gf.led_pause, lp);
    chk({tag, "_rounds"}, gf.rounds, r);
    @(posedge CLK);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ns, np, first, rs, rp;
    bit bounce [4];
    gf.btn_start = 0; gf.btn_pause = 0; gf.time_up = 0; gf.fail = 0;
    RESET = 1;
    @(posedge CLK);
    #1;
    chk_en = 1;
    @(negedge CLK);
    chk("reset_Start", gf.Start, 1'b0);
    chk("reset_pause", gf.pause, 1'b0);
    @(posedge CLK);
    #1;
    at_neg_levels("reset", 1'b0, 1'b0, 1'b0, 4'd0);
    RESET = 0;
    idle(4);

    // clean press: Start seen in the cycle after edge DB+3
    press(0, 10, 10, ns, np, first);
    chk("start_latency", first, DB + 5);
    chk("start_count", ns, 1);
    at_neg_levels("run", 1'b1, 1'b0, 1'b0, 4'd0);

`ifdef PAUSE_FEATURE_EN
    bounce = '{1'b1, 1'b0, 1'b1, 1'b0};
    np = 0;
    for (int k = 0; k < 4; k++) begin
      gf.btn_pause = bounce[k];
      @(negedge CLK);
      if (gf.pause) np++;
      @(posedge CLK);
      #1;
    end
    press(1, 10, 10, ns, first, rs);
    chk("bounce_pause_count", np + first, 1);
    at_neg_levels("paused", 1'b0, 1'b0, 1'b1, 4'd0);
    press(0, 10, 10, ns, np, first);
    chk("resume_start_count", ns, 1);
    at_neg_levels("resumed", 1'b1, 1'b0, 1'b0, 4'd0);
`else
    bounce = '{1'b0, 1'b0, 1'b0, 1'b0};
    press(1, 10, 10, ns, np, first);
    chk("nopause_pulse_count", np + 32'(bounce[0]), 0);
    at_neg_levels("nopause", 1'b1, 1'b0, 1'b0, 4'd0);
`endif

    // time_up arrives on the same edge as a pause event
    np = 0;
    for (int k = 1; k <= 20; k++) begin
      gf.btn_pause = (k <= 10);
      if (k == 8) gf.time_up = 1;
      @(negedge CLK);
      if (gf.pause) np++;
      @(posedge CLK);
      #1;
    end
    gf.time_up = 0;
    chk("timeup_pause_count", np, 0);
    at_neg_levels("over", 1'b0, 1'b1, 1'b0, 4'd1);

    // repeated games ending in fail: rounds saturates at 15
    for (int g = 1; g <= 16; g++) begin
      press(0, 10, 10, ns, np, first);
      chk("rearm_start", ns, 1);
      press(0, 10, 10, ns, np, first);
      gf.fail = 1;
      idle(1);
      gf.fail = 0;
      idle(1);
      @(negedge CLK);
      chk("rounds_sat", gf.rounds, (g + 1 > 15) ? 15 : g + 1);
      @(posedge CLK);
      #1;
    end

    // randomized button bouncing, timer and fail activity
    rs = 0; rp = 0;
    for (int c = 0; c < 2500; c++) begin
      if (rs == 0) begin gf.btn_start = ~gf.btn_start; rs = $urandom_range(1, 10); end
      if (rp == 0) begin gf.btn_pause = ~gf.btn_pause; rp = $urandom_range(1, 10); end
      rs = rs - 1;
      rp = rp - 1;
      gf.time_up = ($urandom_range(0, 63) == 0);
      gf.fail    = ($urandom_range(0, 99) == 0);
      idle(1);
    end
    gf.btn_start = 0; gf.btn_pause = 0; gf.time_up = 0; gf.fail = 0;
    idle(10);

    // reset mid-RUN while start is held
    RESET = 1;
    idle(2);
    RESET = 0;
    idle(4);
    press(0, 10, 10, ns, np, first);
    at_neg_levels("run2", 1'b1, 1'b0, 1'b0, 4'd0);
    gf.btn_start = 1;
    idle(12);
    RESET = 1;
    idle(1);
    @(negedge CLK);
    chk("midreset_Start", gf.Start, 1'b0);
    chk("midreset_playing", gf.playing, 1'b0);
    @(posedge CLK);
    #1;
    RESET = 0;
    press(0, 20, 10, ns, np, first);
    chk("held_no_start", ns, 0);
    at_neg_levels("held", 1'b0, 1'b0, 1'b0, 4'd0);
    press(0, 10, 10, ns, np, first);
    chk("repress_start", ns, 1);
    at_neg_levels("repress", 1'b1, 1'b0, 1'b0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 1000000, SHALL set the debounce stability window in CLK cycles (10 ms at 100 MHz), range 2..2^20-1.
REQ-002 CLK  input  1  system clock; all logic SHALL be on its rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 btn_start  input  1  raw, bouncy, asynchronous start/resume/restart button, active-high.
REQ-005 btn_pause  input  1  raw, bouncy, asynchronous pause button, active-high.
REQ-006 time_up  input  1  level from the countdown timer; high means the timer is in its expired state.
REQ-007 fail  input  1  level from game logic; high means the player lost before time expired.
REQ-008 Start  output  1  one-cycle pulse to the countdown timer: begin, resume or re-arm.
REQ-009 pause  output  1  one-cycle pulse to the countdown timer: stop counting.
REQ-010 game_over  output  1  level to the countdown timer; high while in OVER.
REQ-011 playing  output  1  level; high only in RUN.
REQ-012 led_pause  output  1  level; high only in PAUSED.
REQ-013 rounds  output  4  count of completed games, saturating.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer, then a 20-bit stability counter: counter clears whenever the synced value equals the debounced level, increments otherwise, and the debounced level SHALL flip when the counter reaches DB_CYCLES-1.
REQ-015 A press event SHALL be a single-cycle rising edge of a debounced level; release and bounce shorter than DB_CYCLES SHALL generate no event.
REQ-016 FSM states SHALL be IDLE, RUN, PAUSED, OVER; all outputs SHALL be registered and change on the same edge as the state register.
REQ-017 IDLE: start event -> RUN with Start=1; all other inputs ignored.
REQ-018 RUN: time_up or fail -> OVER; else pause event -> PAUSED with pause=1; start events ignored.
REQ-019 PAUSED: start or pause event -> RUN with Start=1; fail and time_up ignored.
REQ-020 OVER: start event -> IDLE with Start=1 (re-arms the timer); entry to OVER SHALL increment rounds, saturating at 15.
REQ-021 Simultaneous events in RUN: time_up/fail SHALL win over pause; simultaneous start and pause events in PAUSED SHALL produce exactly one Start pulse.
REQ-022 Start and pause SHALL never be high in the same cycle, and neither SHALL be high for two consecutive cycles.
REQ-023 Latency: a clean button rise sampled at edge 0 SHALL produce its output pulse in the cycle after edge DB_CYCLES+3.

Reset
REQ-024 RESET SHALL, on the next edge regardless of state, force IDLE, clear synchronizers, debounce counters, debounced levels, and rounds, and drive Start=0, pause=0, game_over=0, playing=0, led_pause=0.
REQ-025 A button held during RESET release SHALL not produce an event until released and pressed again.

Configuration
REQ-026 Macro PAUSE_FEATURE_EN defined: pause behaviour as REQ-018/019.
REQ-027 PAUSE_FEATURE_EN undefined: btn_pause path SHALL not be built, pause and led_pause SHALL be constant 0, PAUSED SHALL be unreachable; all else unchanged.

Verification (DB_CYCLES=4)
REQ-028 Reset, btn_start high 10 cycles -> one Start pulse 7 cycles after first sample, playing=1, rounds=0.
REQ-029 In RUN, btn_pause bounces 1-0-1-0 single-cycle then holds high -> exactly one pause pulse, led_pause=1; then btn_start press -> one Start pulse, playing=1.
REQ-030 In RUN, time_up and a pause event in the same cycle -> OVER, game_over=1, no pause pulse, rounds=1.
REQ-031 Complete 16 games via fail -> rounds=15 after 15th and stays 15 after 16th.
REQ-032 RESET asserted mid-RUN with btn_start held -> IDLE, all outputs 0, no Start until btn_start is released and re-pressed.
REQ-033 Build without PAUSE_FEATURE_EN, press btn_pause in RUN -> pause=0, led_pause=0, state remains RUN.
